// File: rtl/timer_counter_if.sv
// Bus-responder interface between the system bridge and the timer.
// The bridge drives select, strobe, address and store data; the timer returns read data and irq.
interface timer_counter_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output sel,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  sel,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a maskable interrupt.
// Reads are combinational from addr[3:2]; writes and FSM updates commit on the rising clock edge.
module timer_counter (
  input  logic       clk,
  input  logic       reset,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic       ctrl_en;
  logic       mode_reload;
  logic       ctrl_im;
  logic [1:0] reg_idx;
  logic       wr_ctrl;
  logic       wr_preset;

  // Only addr[3:2] is decoded.
  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

  assign ctrl_en     = ctrl_q[0];
  assign mode_reload = (ctrl_q[2:1] == 2'b01);
  assign ctrl_im     = ctrl_q[3];
  assign reg_idx     = bus.addr[3:2];
  assign wr_ctrl     = bus.sel & bus.we & (reg_idx == AddrCtrl);
  assign wr_preset   = bus.sel & bus.we & (reg_idx == AddrPreset);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_en) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!ctrl_en) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = StInt;
        end
      end
      StInt: begin
        if (mode_reload) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // CPU writes come last so they override the hardware EN clear and the flag set.
    if (wr_ctrl) begin
      ctrl_d = bus.wdata[3:0];
    end
    if (wr_preset) begin
      preset_d = bus.wdata;
    end
    if (wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    unique case (reg_idx)
      AddrCtrl:   bus.rdata = {28'd0, ctrl_q};
      AddrPreset: bus.rdata = preset_q;
      AddrCount:  bus.rdata = count_q;
      default:    bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = irq_flag_q & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register-access vector table plus hand-written
// sequences for countdown, reload, disable, collisions and mid-count reset.
module tb_timer_counter;

  logic clk;
  logic reset;

  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    chk(name, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    logic        exp_irq;
    int          p;

    n_cmp  = 0;
    n_fail = 0;

    //            sel   we    addr          wdata         rd_addr       exp_rdata     irq
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h4,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h8,        32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        32'hC,        32'h0,        1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h4,        32'hDEADBEEF, 32'h4,        32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h4,        32'h12345678, 32'h4,        32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h4,        32'h00001111, 32'h4,        32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h8,        32'hFFFFFFFF, 32'h8,        32'h0,        1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'hC,        32'hFFFFFFFF, 32'hC,        32'h0,        1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0,        32'hFFFFFFF8, 32'h0,        32'h8,        1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'hABCD0004, 32'h00000005, 32'h10000004, 32'h5,        1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h0,        32'h00000006, 32'h0,        32'h6,        1'b0};
    vecs[12] = '{1'b1, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b1, 32'h4,        32'h0,        32'h4,        32'h0,        1'b0};

    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Register access table; EN stays 0 so the counter never runs here.
    for (int i = 0; i < 14; i++) begin
      bus.sel   = vecs[i].sel;
      bus.we    = vecs[i].we;
      bus.addr  = vecs[i].addr;
      bus.wdata = vecs[i].wdata;
      tick();
      bus.sel  = 1'b0;
      bus.we   = 1'b0;
      bus.addr = vecs[i].rd_addr;
      #1;
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      irq_chk($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    end

    // One-shot, N=5.
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    tick();
    tick();
    for (int i = 0; i <= 5; i++) begin
      rd_chk($sformatf("os_count%0d", i), 32'h8, 32'(5 - i));
      irq_chk($sformatf("os_irq%0d", i), (i == 5));
      if (i < 5) tick();
    end
    tick();
    rd_chk("os_ctrl_after", 32'h0, 32'h8);
    for (int i = 0; i < 20; i++) begin
      irq_chk($sformatf("os_irq_hold%0d", i), 1'b1);
      tick();
    end
    wr(32'h0, 32'h0);
    irq_chk("os_irq_cleared", 1'b0);

    // Auto-reload, N=3: pulses at c=5,11,17,23; reload to 3 at c=2+6m.
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c < 2) begin
        exp_cnt = 32'd0;
      end else begin
        p       = (c - 2) % 6;
        exp_cnt = (p < 3) ? 32'(3 - p) : 32'd0;
      end
      exp_irq = (c >= 5) && (((c - 5) % 6) == 0);
      rd_chk($sformatf("ar_count_c%0d", c), 32'h8, exp_cnt);
      irq_chk($sformatf("ar_irq_c%0d", c), exp_irq);
    end
    wr(32'h0, 32'h0);
    tick();
    irq_chk("ar_stop_irq", 1'b0);

    // Mid-count disable: one more decrement at the write edge, then frozen.
    wr(32'h4, 32'd100);
    wr(32'h0, 32'h1);
    repeat (10) tick();
    rd_chk("md_count_before", 32'h8, 32'd92);
    wr(32'h0, 32'h0);
    rd_chk("md_count_write_edge", 32'h8, 32'd91);
    tick();
    rd_chk("md_count_frozen1", 32'h8, 32'd91);
    tick();
    tick();
    rd_chk("md_count_frozen2", 32'h8, 32'd91);
    irq_chk("md_irq", 1'b0);

    // IM=0: countdown completes but irq stays masked.
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    tick();
    tick();
    tick();
    tick();
    rd_chk("mask_count_int", 32'h8, 32'd0);
    irq_chk("mask_irq_int", 1'b0);
    tick();
    rd_chk("mask_ctrl_en_cleared", 32'h0, 32'h0);
    irq_chk("mask_irq_after", 1'b0);

    // PRESET written during CNT: current countdown unchanged, next reload uses 7.
    wr(32'h4, 32'd4);
    wr(32'h0, 32'hB);
    tick();
    tick();
    rd_chk("pc_count_start", 32'h8, 32'd4);
    wr(32'h4, 32'd7);
    rd_chk("pc_count_unaffected", 32'h8, 32'd3);
    tick();
    tick();
    tick();
    rd_chk("pc_count_int", 32'h8, 32'd0);
    irq_chk("pc_irq_int", 1'b1);
    tick();
    tick();
    tick();
    rd_chk("pc_count_reload7", 32'h8, 32'd7);
    repeat (7) tick();
    irq_chk("pc_irq_second", 1'b1);
    wr(32'h0, 32'h0);
    irq_chk("pc_irq_stop", 1'b0);
    tick();

    // CTRL write in INT (one-shot): written value wins over EN clear, flag cleared.
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h9);
    tick();
    tick();
    tick();
    irq_chk("ci_irq_int", 1'b1);
    wr(32'h0, 32'hD);
    rd_chk("ci_ctrl_written", 32'h0, 32'hD);
    irq_chk("ci_irq_cleared", 1'b0);
    tick();
    tick();
    tick();
    irq_chk("ci_mode10_irq", 1'b1);
    tick();
    rd_chk("ci_mode10_oneshot", 32'h0, 32'hC);
    wr(32'h0, 32'h0);

    // PRESET=0 behaves like PRESET=1.
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    tick();
    tick();
    irq_chk("p0_irq_cnt", 1'b0);
    tick();
    irq_chk("p0_irq_int", 1'b1);
    rd_chk("p0_count", 32'h8, 32'd0);
    wr(32'h0, 32'h0);

    // Reset at COUNT=40, with a simultaneous PRESET write that must lose.
    wr(32'h4, 32'd50);
    wr(32'h0, 32'hB);
    repeat (12) tick();
    rd_chk("rst_count_before", 32'h8, 32'd40);
    reset     = 1'b1;
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h4;
    bus.wdata = 32'h55;
    tick();
    reset   = 1'b0;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
    rd_chk("rst_ctrl", 32'h0, 32'h0);
    rd_chk("rst_preset", 32'h4, 32'h0);
    rd_chk("rst_count", 32'h8, 32'h0);
    irq_chk("rst_irq", 1'b0);
    tick();
    rd_chk("rst_count_idle", 32'h8, 32'h0);
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    tick();
    tick();
    rd_chk("rst_re_count2", 32'h8, 32'd2);
    tick();
    rd_chk("rst_re_count1", 32'h8, 32'd1);
    irq_chk("rst_re_irq0", 1'b0);
    tick();
    irq_chk("rst_re_irq1", 1'b1);
    wr(32'h0, 32'h0);
    irq_chk("rst_re_irq_clear", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
